// File: rtl/mul5_sched_pkg.sv
// Shared definitions for the round-robin multiply-by-5 scheduler.
//
// Contents:
//   sched_state_t    - scheduler FSM states (IDLE, CALC, RESP)
//   MUL_FACTOR       - constant multiplier applied to every operand
//   DEFAULT_NUM_REQ  - default number of requesters
//   DEFAULT_DATA_W   - default operand width
package mul5_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    localparam int MUL_FACTOR      = 5;
    localparam int DEFAULT_NUM_REQ = 4;
    localparam int DEFAULT_DATA_W  = 4;

endpackage

// File: rtl/mul5_rr_scheduler_mul5.sv
// Combinational multiply-by-5 datapath for 4-bit operands.
//
// Ports:
//   a  input  [3:0]  unsigned operand
//   y  output [6:0]  a * 5, full width (15 -> 75)
module multiplication_by_5 (
    input  logic [3:0] a,
    output logic [6:0] y
);

    // a*5 = a*4 + a; both terms widened to 7 bits so the carry is kept.
    assign y = {1'b0, a, 2'b00} + {3'b000, a};

endmodule

// File: rtl/mul5_rr_scheduler.sv
// Round-robin scheduler in front of a multiply-by-5 datapath.
// Requesters present operands with req_valid; one is granted per IDLE
// cycle, its operand is multiplied by 5 in CALC and the result is offered
// in RESP until the consumer takes it with rsp_ready.
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   DATA_W   operand width; results are DATA_W+3 bits
//
// Ports:
//   clk        input                      clock, rising edge
//   rst_n      input                      asynchronous active-low reset
//   req_valid  input  [NUM_REQ-1:0]       per-requester operand valid
//   req_data   input  [NUM_REQ*DATA_W-1:0] operand i at [i*DATA_W +: DATA_W]
//   req_ready  output [NUM_REQ-1:0]       one-hot grant (combinational)
//   rsp_valid  output                     result available
//   rsp_data   output [DATA_W+2:0]        operand * 5
//   rsp_id     output [clog2(NUM_REQ)-1:0] requester owning rsp_data
//   rsp_ready  input                      consumer accepts result
//   busy       output                     high whenever not IDLE
//   done_cnt   output [7:0]               completed responses, saturating
//                                         (only with MUL5_SCHED_STATS_EN)
//
// Build option: define MUL5_SCHED_STATS_EN to add the done_cnt counter.
module mul5_rr_scheduler
    import mul5_sched_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int DATA_W  = DEFAULT_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rsp_valid,
    output logic [DATA_W+2:0]             rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    input  logic                          rsp_ready,
    output logic                          busy
`ifdef MUL5_SCHED_STATS_EN
    ,
    output logic [7:0]                    done_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    sched_state_t      state;
    sched_state_t      next_state;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_found;
    logic [IDX_W-1:0]  id_reg;
    logic [DATA_W-1:0] op_reg;
    logic [DATA_W+2:0] product;
    logic [DATA_W-1:0] req_ops [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_ops[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Requester index offset positions after base, wrapping at NUM_REQ.
    // NUM_REQ need not be a power of two, so the wrap is explicit.
    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                  input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDX_W'(sum);
    endfunction

    // Search starts just after the last grant and ends on last_grant itself,
    // so a lone persistent requester is still picked every time.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!grant_found && req_valid[rr_index(last_grant, off)]) begin
                grant_found = 1'b1;
                grant_idx   = rr_index(last_grant, off);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    next_state           = CALC;
                end
            end
            CALC: next_state = RESP;
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // The standard 4-bit datapath is reused when it fits; other widths use
    // an equivalent full-width multiply that cannot truncate.
    if (DATA_W == 4) begin : g_mul_std
        multiplication_by_5 u_mul (
            .a (op_reg),
            .y (product)
        );
    end else begin : g_mul_generic
        assign product = (DATA_W+3)'(op_reg) * (DATA_W+3)'(MUL_FACTOR);
    end

    // Reset leaves last_grant at the top index so requester 0 wins first.
    // rsp_data/rsp_id only change in CALC, which keeps them stable in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IDX_W'(NUM_REQ - 1);
            op_reg     <= '0;
            id_reg     <= '0;
            rsp_data   <= '0;
            rsp_id     <= '0;
        end else begin
            if (state == IDLE && grant_found) begin
                op_reg     <= req_ops[grant_idx];
                id_reg     <= grant_idx;
                last_grant <= grant_idx;
            end
            if (state == CALC) begin
                rsp_data <= product;
                rsp_id   <= id_reg;
            end
        end
    end

`ifdef MUL5_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (rsp_valid && rsp_ready && done_cnt != 8'hFF) begin
            done_cnt <= done_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mul5_rr_scheduler.sv
// Self-checking bench for mul5_rr_scheduler.
// A driver presents queued operands with random valid/ready gaps, a grant
// checker predicts each round-robin grant and pushes the expected response
// into a scoreboard, and a separate monitor pops and compares responses.
// Define MUL5_SCHED_STATS_EN to also check done_cnt.
module tb_mul5_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 4;
    localparam int IDX_W   = $clog2(NUM_REQ);

    typedef struct {
        int id;
        int data;
        int grant_cyc;
    } exp_t;

    logic                      clk       = 1'b0;
    logic                      rst_n     = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic [DATA_W+2:0]         rsp_data;
    logic [IDX_W-1:0]          rsp_id;
    logic                      rsp_ready = 1'b0;
    logic                      busy;
`ifdef MUL5_SCHED_STATS_EN
    logic [7:0]                done_cnt;
`endif

    exp_t              sb[$];
    logic [DATA_W-1:0] pend [NUM_REQ][$];
    int                dut_grant_ids[$];
    int                grant_cycles[$];
    int                resp_len_log[$];
    int                last_grant_m = NUM_REQ - 1;
    logic              in_flight    = 1'b0;
    int                cyc          = 0;
    int                valid_pct    = 100;
    int                rdy_pct      = 100;
    int                n_checks     = 0;
    int                n_fail       = 0;
    int                done_model   = 0;
    bit                mon_seen     = 1'b0;
    int                mon_resp_cyc = 0;
    int                exp_idx;
    int                dut_idx;
    logic [NUM_REQ-1:0] exp_ready;

    mul5_rr_scheduler #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy)
`ifdef MUL5_SCHED_STATS_EN
        ,
        .done_cnt  (done_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int idx, input int data);
        pend[idx].push_back(DATA_W'(data));
    endtask

    function automatic bit all_pend_empty();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pend[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Driver: present the head of each requester queue, randomly gated.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pend[i].size() != 0 && int'($urandom_range(99)) < valid_pct) begin
                    req_valid[i]                  = 1'b1;
                    req_data[i*DATA_W +: DATA_W]  = pend[i][0];
                end else begin
                    req_valid[i]                  = 1'b0;
                    req_data[i*DATA_W +: DATA_W]  = DATA_W'($urandom);
                end
            end
            rsp_ready = (int'($urandom_range(99)) < rdy_pct);
        end
    end

    // Grant checker: reference round-robin choice from the driven valids.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                exp_idx = -1;
                if (!in_flight) begin
                    for (int k = 1; k <= NUM_REQ; k++) begin
                        int cand;
                        cand = (last_grant_m + k) % NUM_REQ;
                        if (exp_idx < 0 && req_valid[IDX_W'(cand)]) exp_idx = cand;
                    end
                end
                exp_ready = (exp_idx >= 0) ? (NUM_REQ'(1) << exp_idx) : '0;
                checkOutput("req_ready", int'(req_ready), int'(exp_ready));
                checkOutput("busy", int'(busy), int'(in_flight));
                if (exp_idx >= 0) begin
                    dut_idx = -1;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (dut_idx < 0 && req_ready[i]) dut_idx = i;
                    end
                    sb.push_back('{exp_idx, int'(pend[exp_idx][0]) * 5, cyc});
                    void'(pend[exp_idx].pop_front());
                    last_grant_m = exp_idx;
                    in_flight   <= 1'b1;
                    dut_grant_ids.push_back(dut_idx);
                    grant_cycles.push_back(cyc);
                end
            end
        end
    end

    // Monitor: compare each presented response with the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_seen     = 1'b0;
                mon_resp_cyc = 0;
            end else begin
`ifdef MUL5_SCHED_STATS_EN
                checkOutput("done_cnt", int'(done_cnt), done_model);
`endif
                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        checkOutput("rsp_valid_without_request", int'(rsp_valid), 0);
                    end else begin
                        mon_resp_cyc++;
                        if (!mon_seen) checkOutput("rsp_latency", cyc - sb[0].grant_cyc, 2);
                        mon_seen = 1'b1;
                        checkOutput("rsp_data", int'(rsp_data), sb[0].data);
                        checkOutput("rsp_id", int'(rsp_id), sb[0].id);
                        if (rsp_ready) begin
                            void'(sb.pop_front());
                            in_flight <= 1'b0;
                            resp_len_log.push_back(mon_resp_cyc);
                            mon_resp_cyc = 0;
                            mon_seen     = 1'b0;
                            if (done_model < 255) done_model++;
                        end
                    end
                end
            end
        end
    end

    task automatic resetPulse(input string name);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        for (int i = 0; i < NUM_REQ; i++) pend[i].delete();
        in_flight   <= 1'b0;
        last_grant_m = NUM_REQ - 1;
        done_model   = 0;
        #1;
        checkOutput({name, "_rsp_valid"}, int'(rsp_valid), 0);
        checkOutput({name, "_rsp_data"}, int'(rsp_data), 0);
        checkOutput({name, "_rsp_id"}, int'(rsp_id), 0);
        checkOutput({name, "_busy"}, int'(busy), 0);
`ifdef MUL5_SCHED_STATS_EN
        checkOutput({name, "_done_cnt"}, int'(done_cnt), 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic waitIdle(input int max_cycles, input string name);
        int n;
        n = 0;
        while (n < max_cycles &&
               !(all_pend_empty() && sb.size() == 0 && !busy && !in_flight)) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput({name, "_timeout"}, int'(n >= max_cycles), 0);
    endtask

    initial begin
        int n0;
        int n;

        valid_pct = 100;
        rdy_pct   = 100;
        resetPulse("reset");

        // Single requester 0 with operand 3
        applyStimulus(0, 3);
        waitIdle(50, "single");

        // All four requesters with 15 straight after reset
        resetPulse("reset2");
        n0 = dut_grant_ids.size();
        for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 15);
        waitIdle(100, "all_four");
        checkOutput("all_four_grants", dut_grant_ids.size() - n0, 4);
        if (dut_grant_ids.size() >= n0 + 4) begin
            for (int k = 0; k < 4; k++) checkOutput("all_four_order", dut_grant_ids[n0 + k], k);
            for (int k = 1; k < 4; k++)
                checkOutput("all_four_interval", grant_cycles[n0 + k] - grant_cycles[n0 + k - 1], 3);
        end

        // Consumer stalls for 5 cycles while others wait
        n0      = resp_len_log.size();
        rdy_pct = 0;
        applyStimulus(1, 11);
        n = 0;
        while (n < 20 && !rsp_valid) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("stall_rsp_timeout", int'(n >= 20), 0);
        applyStimulus(0, 1);
        applyStimulus(3, 2);
        repeat (4) @(negedge clk);
        rdy_pct = 100;
        waitIdle(100, "stall");
        if (resp_len_log.size() > n0) checkOutput("stall_resp_cycles", resp_len_log[n0], 6);
        else checkOutput("stall_resp_count", resp_len_log.size() - n0, 1);

        // Reset while requester 2 is in CALC
        n0 = grant_cycles.size();
        applyStimulus(2, 9);
        n = 0;
        while (n < 20 && grant_cycles.size() == n0) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("calc_grant_timeout", int'(n >= 20), 0);
        resetPulse("calc_reset");
        n0 = dut_grant_ids.size();
        applyStimulus(2, 4);
        applyStimulus(0, 6);
        waitIdle(100, "after_reset");
        checkOutput("after_reset_grants", dut_grant_ids.size() - n0, 2);
        if (dut_grant_ids.size() > n0) checkOutput("after_reset_first_grant", dut_grant_ids[n0], 0);

        // Operands 0..15 on requester 1
        resetPulse("reset3");
        for (int i = 0; i < 16; i++) applyStimulus(1, i);
        waitIdle(200, "sweep");
`ifdef MUL5_SCHED_STATS_EN
        checkOutput("done_cnt_16", int'(done_cnt), 16);
`endif

        // Randomised traffic with valid and ready gaps
        valid_pct = 70;
        rdy_pct   = 60;
        for (int i = 0; i < 300; i++)
            applyStimulus(int'($urandom_range(NUM_REQ - 1)), int'($urandom_range(15)));
        waitIdle(20000, "random");
`ifdef MUL5_SCHED_STATS_EN
        checkOutput("done_cnt_saturated", int'(done_cnt), 255);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mul5_rr_scheduler.md
MUL5_RR_SCHEDULER -- requirements
Module: mul5_rr_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning number of requesters (2..8).
REQ-002 The block SHALL have parameter DATA_W, default 4, meaning operand width; result width is DATA_W+3.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port req_valid  input  NUM_REQ  per-requester operand valid.
REQ-006 The block SHALL have port req_data  input  NUM_REQ*DATA_W  operands, requester i at bits [i*DATA_W +: DATA_W].
REQ-007 The block SHALL have port req_ready  output  NUM_REQ  one-hot grant, combinational from state, pointer and req_valid.
REQ-008 The block SHALL have port rsp_valid  output  1  result available.
REQ-009 The block SHALL have port rsp_data  output  DATA_W+3  operand times 5.
REQ-010 The block SHALL have port rsp_id  output  clog2(NUM_REQ)  index of the requester owning rsp_data.
REQ-011 The block SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-012 The block SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, CALC and RESP only.
REQ-014 In IDLE, req_ready SHALL be asserted for exactly one valid requester: the first with req_valid high searching from (last_grant+1) mod NUM_REQ upward with wrap-around; all bits zero if none valid.
REQ-015 On an IDLE cycle with req_valid[i] and req_ready[i] high, the block SHALL latch operand and index i, set last_grant=i and move to CALC.
REQ-016 In CALC, the block SHALL register operand*5, zero-extended to DATA_W+3 bits with no truncation (15 -> 75), into rsp_data, register the index into rsp_id, and move to RESP.
REQ-017 In RESP, rsp_valid SHALL be high; rsp_data and rsp_id SHALL hold stable until rsp_ready is sampled high, after which the state SHALL return to IDLE.
REQ-018 rsp_valid SHALL rise exactly 2 cycles after the accepting edge; minimum issue interval SHALL be 3 cycles.
REQ-019 req_ready SHALL be all-zero in CALC and RESP; requests arriving then SHALL wait, with no loss and no reordering within one requester.
REQ-020 Dropping req_valid in IDLE before a grant edge SHALL cancel that request with no side effect.
REQ-021 rsp_ready high outside RESP SHALL be ignored.
REQ-022 With a single persistently valid requester, it SHALL be granted on every IDLE visit.

Reset
REQ-023 When rst_n is low, state SHALL be IDLE, last_grant NUM_REQ-1 (so requester 0 has first priority), and rsp_valid, rsp_data, rsp_id and busy SHALL be 0, asynchronously.
REQ-024 Reset asserted in CALC or RESP SHALL abandon the operation with no response; the first grant after release SHALL follow REQ-014 from requester 0.

Configuration
REQ-025 With MUL5_SCHED_STATS_EN defined, the block SHALL add output done_cnt [7:0], reset 0, incremented on each RESP handshake and saturating at 255.
REQ-026 Without MUL5_SCHED_STATS_EN, done_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 A shared package mul5_sched_pkg SHALL hold the FSM state typedef (IDLE/CALC/RESP), the constant MUL_FACTOR=5, and the default NUM_REQ/DATA_W constants.
REQ-028 The multiply SHALL be done by one instance of the team's existing combinational multiplication_by_5 datapath (4-bit in, 7-bit out) for DATA_W=4; arbitration and FSM stay in mul5_rr_scheduler.

Verification
REQ-029 Requester 0 only, data 3, rsp_ready tied high -> req_ready=4'b0001, rsp_valid 2 cycles later, rsp_data=15, rsp_id=0, back to IDLE.
REQ-030 All four valid with data 15 after reset -> grants in order 0,1,2,3, each rsp_data=75, rsp_id matching order, one issue every 3 cycles.
REQ-031 rsp_ready low for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable for all 5 cycles, req_ready=0; handshake on cycle 6.
REQ-032 rst_n pulsed low while in CALC for requester 2 -> outputs 0 immediately, no response issued, next grant goes to requester 0.
REQ-033 Inputs 0..15 on requester 1 -> rsp_data=5*i for each; with MUL5_SCHED_STATS_EN, done_cnt=16, and after 300 operations done_cnt=255.
